// File: rtl/button_multi_press_if.sv
// Press-pulse input and gesture-event output bundle for button_multi_press.
// The slave modport is the classifier; the master is whoever drives pulses and consumes events.
interface button_multi_press_if #(
   parameter int MAX_PRESSES = 3
);
   localparam int CW = $clog2(MAX_PRESSES + 1);

   logic          pulse;
   logic          event_valid;
   logic [CW-1:0] event_count;
   logic          busy;

   modport master (
      output pulse,
      input  event_valid,
      input  event_count,
      input  busy
   );

   modport slave (
      input  pulse,
      output event_valid,
      output event_count,
      output busy
   );
endinterface

// File: rtl/button_multi_press.sv
// Groups single-cycle press pulses into counted gestures (single, double, ...)
// and emits one registered event per gesture on timeout or on reaching MAX_PRESSES.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// IDLE     | no gesture open; a pulse opens one with count 1
// COUNTING | gesture open; more pulses add to it, window expiry closes it
module button_multi_press #(
   parameter int WINDOW      = 12_500_000,
   parameter int MAX_PRESSES = 3
) (
   input logic                 clk,
   input logic                 reset,
   button_multi_press_if.slave bus
);
   localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int CW = $clog2(MAX_PRESSES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW - 1);
   localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_PRESSES);

   typedef enum logic {
      IDLE,
      COUNTING
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] count, count_next;
   logic [TW-1:0] timer, timer_next;
   logic          emit;
   logic [CW-1:0] emit_count;
   logic          event_valid_q;
   logic [CW-1:0] event_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         timer         <= '0;
         event_valid_q <= 1'b0;
         event_count_q <= '0;
      end else begin
         state         <= state_next;
         count         <= count_next;
         timer         <= timer_next;
         event_valid_q <= emit;
         event_count_q <= emit ? emit_count : '0;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      timer_next = timer;
      emit       = 1'b0;
      emit_count = '0;
      case (state)
         IDLE: begin
            if (bus.pulse) begin
               state_next = COUNTING;
               count_next = CW'(1);
               timer_next = '0;
            end
         end
         COUNTING: begin
            // A pulse always beats the timeout, even on the last window cycle.
            if (bus.pulse) begin
               if (count + CW'(1) == COUNT_MAX) begin
                  emit       = 1'b1;
                  emit_count = COUNT_MAX;
                  count_next = '0;
                  timer_next = '0;
                  state_next = IDLE;
               end else begin
                  count_next = count + CW'(1);
                  timer_next = '0;
               end
            end else if (timer == TIMER_LAST) begin
               emit       = 1'b1;
               emit_count = count;
               count_next = '0;
               timer_next = '0;
               state_next = IDLE;
            end else begin
               timer_next = timer + TW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
            timer_next = '0;
         end
      endcase
   end

   always_comb begin
      bus.busy        = (state == COUNTING);
      bus.event_valid = event_valid_q;
      bus.event_count = event_count_q;
   end
endmodule

// File: tb/tb_button_multi_press.sv
// Directed bench for button_multi_press with WINDOW=8, MAX_PRESSES=3; cycle numbers
// count from reset release and every expected event/busy cycle is written out by hand.
module tb_button_multi_press;
   localparam int WINDOW      = 8;
   localparam int MAX_PRESSES = 3;
   localparam int NCYC        = 45;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   button_multi_press_if #(.MAX_PRESSES(MAX_PRESSES)) bus ();

   button_multi_press #(
      .WINDOW     (WINDOW),
      .MAX_PRESSES(MAX_PRESSES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m;
      m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] bit_at(input int a);
      logic [63:0] m;
      m = '0;
      m[a] = 1'b1;
      return m;
   endfunction

   // Runs one scenario from a fresh reset; ev_cyc entries of -1 mean "no event".
   task automatic run_scenario(input int id, input logic [63:0] pulses, input int rst_cyc,
                               input int ev_c0, input int ev_n0,
                               input int ev_c1, input int ev_n1,
                               input logic [63:0] busy_exp);
      int exp_v, exp_n;
      reset     = 1'b1;
      bus.pulse = 1'b0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < NCYC; c++) begin
         reset     = (c == rst_cyc);
         bus.pulse = pulses[c];
         exp_v = 0;
         exp_n = 0;
         if (c == ev_c0) begin exp_v = 1; exp_n = ev_n0; end
         if (c == ev_c1) begin exp_v = 1; exp_n = ev_n1; end
         check_eq($sformatf("s%0d_c%0d_event_valid", id, c), int'(bus.event_valid), exp_v);
         check_eq($sformatf("s%0d_c%0d_event_count", id, c), int'(bus.event_count), exp_n);
         check_eq($sformatf("s%0d_c%0d_busy", id, c), int'(bus.busy), int'(busy_exp[c]));
         @(negedge clk);
      end
      reset     = 1'b0;
      bus.pulse = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      bus.pulse = 1'b0;

      // single press, closes by timeout
      run_scenario(1, bit_at(10), -1, 19, 1, -1, 0, rng(11, 18));
      // double press
      run_scenario(2, bit_at(10) | bit_at(14), -1, 23, 2, -1, 0, rng(11, 22));
      // triple closes at MAX_PRESSES
      run_scenario(3, bit_at(10) | bit_at(12) | bit_at(14), -1, 15, 3, -1, 0, rng(11, 14));
      // pulse on last window cycle joins the gesture
      run_scenario(4, bit_at(10) | bit_at(18), -1, 27, 2, -1, 0, rng(11, 26));
      // pulse one cycle late: separate gesture started in the event cycle
      run_scenario(5, bit_at(10) | bit_at(19), -1, 19, 1, 28, 1, rng(11, 18) | rng(20, 27));
      // back-to-back presses 10..13
      run_scenario(6, rng(10, 13), -1, 13, 3, 22, 1, rng(11, 12) | rng(14, 21));
      // reset mid-gesture discards it; later press still works
      run_scenario(7, bit_at(10) | bit_at(12) | bit_at(20), 15, 29, 1, -1, 0,
                   rng(11, 15) | rng(21, 28));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/button_multi_press.md
# button_multi_press

Classifies the single-cycle press pulses from the `button` chain into counted gestures: single, double, triple and so on. Presses that arrive within a programmable inter-press window are grouped into one gesture. When the window expires, or the maximum count is reached, the block emits one event that carries the press count. It sits directly downstream of the `button` pulse output and feeds the game-control FSMs, so one physical button can drive several actions.

## Interface
- `WINDOW`, default 12_500_000: maximum gap, in clk cycles, between consecutive presses of one gesture. Legal range ≥ 2.
- `MAX_PRESSES`, default 3: press count at which a gesture closes immediately. Legal range 2..7.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pulse`  in  1  one-cycle press pulse from the `button` block. Back-to-back highs are legal, and each high cycle counts as one press.
- `event_valid`  out  1  one-cycle strobe marking a completed gesture.
- `event_count`  out  $clog2(MAX_PRESSES+1)  number of presses in the gesture. Valid only while `event_valid` is high, and held at 0 otherwise.
- `busy`  out  1  high while a gesture is open (state COUNTING).

## Operation
- Reset values: state=IDLE, press counter=0, timer=0, `event_valid`=0, `event_count`=0, `busy`=0.
- Reset mid-gesture discards the open gesture; no event is emitted.
- State IDLE:
  - `pulse`=1 → COUNTING, counter=1, timer=0.
  - Otherwise stay in IDLE.
- State COUNTING, checked in priority order each cycle:
  - `pulse`=1 and counter+1 == MAX_PRESSES → emit an event with count MAX_PRESSES, counter=0, → IDLE.
  - `pulse`=1 otherwise → counter+1, timer=0, stay in COUNTING.
  - `pulse`=0 and timer == WINDOW-1 → emit an event with the current counter value, counter=0, → IDLE.
  - `pulse`=0 otherwise → timer+1.
- The timer is $clog2(WINDOW) bits wide and never wraps, because it is cleared before reaching WINDOW.
- The counter never exceeds MAX_PRESSES, so there is no overflow.
- Emit means `event_valid` and `event_count` are registered high and valid for exactly one cycle, then return to 0.
- Simultaneous events:
  - A pulse arriving in the cycle where timer == WINDOW-1 joins the open gesture; the pulse wins over the timeout.
  - A pulse arriving in the cycle where `event_valid` is high finds the FSM already in IDLE. It starts a new gesture, so no press is lost.
- No gesture with count 0 is ever emitted.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Latency for a gesture that closes by timeout: `event_valid` goes high exactly WINDOW+1 cycles after the last accepted pulse.
- Latency for a gesture that closes at MAX_PRESSES: `event_valid` goes high 1 cycle after the closing pulse.
- `busy`:
  - Rises 1 cycle after the opening pulse.
  - Falls in the same cycle `event_valid` rises.
  - Stays low for the closing cycle even if a new pulse arrives then. It rises again 1 cycle later.
- Throughput: at most one event per cycle. Event spacing is bounded by the gesture rules above.

## Test plan
All scenarios use WINDOW=8, MAX_PRESSES=3, with cycle numbers counted from the release of reset.
- Single pulse at cycle 10 → `event_valid`=1 with `event_count`=1 at cycle 19 only. `busy` is high for cycles 11..18.
- Pulses at 10 and 14 → one event with count 2 at cycle 23. No event before that.
- Pulses at 10, 12 and 14 → event with count 3 at cycle 15. `busy`=0 at cycle 15.
- Window boundary, two runs:
  - Pulses at 10 and 18 → one event with count 2 at cycle 27 (the pulse wins over the timeout).
  - Pulses at 10 and 19 → an event with count 1 at 19, then an event with count 1 at 28.
- Back-to-back pulses at cycles 10..13 → event with count 3 at 13. The pulse at 13 opens a new gesture, giving an event with count 1 at 22.
- Pulses at 10 and 12, then `reset` high at cycle 15 → no event ever. All outputs are 0 from cycle 16. A pulse at 20 then produces an event with count 1 at 29.
